// File: rtl/ber_counter.sv
// ber_counter
//   Turns the per-word error count from prbs_checker into a bit error rate
//   measurement: bits and errored bits are accumulated over a programmable
//   number of locked words (or until stopped). BER = err_cnt / bit_cnt.
//
// Ports
//   clk        rising-edge clock shared with prbs_generate / prbs_checker
//   reset      synchronous, active-low
//   en         word-valid strobe (same as prbs_checker.en)
//   lock       prbs_checker lock indication
//   err_num    errored bits in the current word, 0..WIDTH
//   start      one-cycle request to begin a measurement
//   stop       one-cycle request to end a measurement early
//   window     number of locked words to measure, 0 = until stop
//   busy       measurement in progress (waiting for lock or measuring)
//   done       one-cycle pulse when a measurement finishes
//   bit_cnt    bits counted (WIDTH per counted word), saturating
//   err_cnt    sum of err_num over counted words, saturating
//   lock_lost  sticky, lock dropped while measuring
//   err_sat    sticky, err_cnt hit its ceiling
module ber_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 48,
  parameter int ERR_W = 32,
  parameter int WIN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             lock,
  input  logic [WIDTH:0]   err_num,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lock_lost,
  output logic             err_sat
);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, MEASURE, DONE} state_t;

  // The error adder must be wide enough for both operands plus a carry,
  // including configurations where ERR_W is narrower than err_num.
  localparam int ESUM_W = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;

  state_t           state;
  logic [WIN_W-1:0] window_q;
  logic [WIN_W-1:0] word_cnt;

  // bit_cnt + WIDTH, clamped at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_bits(input logic [CNT_W-1:0] cur);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + (CNT_W + 1)'(WIDTH);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // err_cnt + err_num (unsigned), clamped; MSB of the result flags a clamp.
  function automatic logic [ERR_W:0] sat_err(input logic [ERR_W-1:0] cur,
                                              input logic [WIDTH:0]   inc);
    logic [ESUM_W-1:0] sum;
    sum = ESUM_W'(cur) + ESUM_W'(inc);
    if (sum > ESUM_W'({ERR_W{1'b1}})) return {1'b1, {ERR_W{1'b1}}};
    return {1'b0, sum[ERR_W-1:0]};
  endfunction

  logic             count_word;
  logic             win_end;
  logic [ERR_W:0]   err_next;
  logic [WIN_W-1:0] word_next;

  assign count_word = en && lock;
  assign word_next  = word_cnt + WIN_W'(1);
  // Window ends on the edge that counts the final word, so it is included.
  assign win_end    = count_word && (window_q != '0) && (word_next == window_q);
  assign err_next   = sat_err(err_cnt, err_num);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
      lock_lost <= 1'b0;
      err_sat   <= 1'b0;
      window_q  <= '0;
      word_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // stop is ignored here, so start+stop together is just a start.
          if (start) begin
            bit_cnt   <= '0;
            err_cnt   <= '0;
            lock_lost <= 1'b0;
            err_sat   <= 1'b0;
            word_cnt  <= '0;
            window_q  <= window;
            busy      <= 1'b1;
            state     <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (lock) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (!lock) lock_lost <= 1'b1;
          if (count_word) begin
            bit_cnt  <= sat_bits(bit_cnt);
            err_cnt  <= err_next[ERR_W-1:0];
            word_cnt <= word_next;
            if (err_next[ERR_W]) err_sat <= 1'b1;
          end
          // A stop coinciding with the window end yields a single DONE.
          if (stop || win_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_counter.sv
module tb_ber_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        lock = 1'b0;
  logic [8:0]  err_num = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] window = '0;

  logic        busy, done, lock_lost, err_sat;
  logic [47:0] bit_cnt;
  logic [31:0] err_cnt;

  logic        s_busy, s_done, s_lock_lost, s_err_sat;
  logic [47:0] s_bit_cnt;
  logic [3:0]  s_err_cnt;

  int checks = 0;
  int errors = 0;

  ber_counter dut (
    .clk(clk), .reset(reset), .en(en), .lock(lock), .err_num(err_num),
    .start(start), .stop(stop), .window(window),
    .busy(busy), .done(done), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
    .lock_lost(lock_lost), .err_sat(err_sat)
  );

  // Narrow error counter instance, sharing all stimulus with the main one.
  ber_counter #(.ERR_W(4)) dut_s (
    .clk(clk), .reset(reset), .en(en), .lock(lock), .err_num(err_num),
    .start(start), .stop(stop), .window(window),
    .busy(s_busy), .done(s_done), .bit_cnt(s_bit_cnt), .err_cnt(s_err_cnt),
    .lock_lost(s_lock_lost), .err_sat(s_err_sat)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 waiting for lock, 2 measuring, 3 finished.
  localparam longint CNT_MAX = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint ERR_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint SERR_MAX = 15;
  int     m_phase = 0;
  longint m_bits = 0, m_err = 0, m_serr = 0, m_words = 0, m_win = 0;
  bit     m_sat = 0, m_ssat = 0, m_lost = 0;

  task automatic model_update();
    bit ended;
    ended = 0;
    if (!reset) begin
      m_phase = 0; m_bits = 0; m_err = 0; m_serr = 0; m_words = 0; m_win = 0;
      m_sat = 0; m_ssat = 0; m_lost = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_bits = 0; m_err = 0; m_serr = 0; m_words = 0; m_win = window;
          m_sat = 0; m_ssat = 0; m_lost = 0; m_phase = 1;
        end
        1: if (stop) m_phase = 3; else if (lock) m_phase = 2;
        2: begin
          ended = stop;
          if (!lock) m_lost = 1;
          if (en && lock) begin
            m_bits = (m_bits + 8 > CNT_MAX) ? CNT_MAX : m_bits + 8;
            m_err  = m_err + err_num;
            if (m_err > ERR_MAX) begin m_err = ERR_MAX; m_sat = 1; end
            m_serr = m_serr + err_num;
            if (m_serr > SERR_MAX) begin m_serr = SERR_MAX; m_ssat = 1; end
            m_words++;
            if (m_win != 0 && m_words == m_win) ended = 1;
          end
          if (ended) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Starts a measurement and runs up to 400 cycles of stimulus, noting the
  // cycle (counted from the start edge) of the first done pulse.
  task automatic run_meas(input int win, input int err_period, input int err_val,
                          input int lock_from, input int lock_len,
                          input int en_from, input int en_len, input int stop_at,
                          output int done_at, output int n_done);
    done_at = -1; n_done = 0;
    lock = 1; en = 1; err_num = 0; stop = 0;
    start = 1; window = win;
    tick();
    start = 0;
    for (int i = 1; i <= 400; i++) begin
      lock = !(i >= lock_from && i < lock_from + lock_len);
      en   = !(i >= en_from && i < en_from + en_len);
      err_num = (err_period != 0 && i % err_period == 0) ? 9'(err_val) : 9'd0;
      stop = (i == stop_at);
      tick();
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
    end
    stop = 0; lock = 1; en = 1; err_num = 0;
  endtask

  task automatic test_reset();
    reset = 0; start = 1; lock = 1; en = 1; err_num = 5; window = 10;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: busy=%0b done=%0b, want 0 0", busy, done); end
    checks++; if (bit_cnt !== 48'd0 || err_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_cnt: bit_cnt=%0d err_cnt=%0d, want 0 0", bit_cnt, err_cnt); end
    checks++; if (lock_lost !== 1'b0 || err_sat !== 1'b0 || s_err_sat !== 1'b0) begin errors++;
      $display("FAIL reset_flags: lock_lost=%0b err_sat=%0b s_err_sat=%0b, want 0", lock_lost, err_sat, s_err_sat); end
    reset = 1; start = 0;
    tick();
  endtask

  task automatic test_window();
    int da, nd;
    run_meas(100, 0, 0, 0, 0, 0, 0, 0, da, nd);
    checks++; if (nd !== 1 || da !== 101) begin errors++;
      $display("FAIL window_done: pulses=%0d at=%0d, want 1 at 101", nd, da); end
    checks++; if (bit_cnt !== 48'd800 || err_cnt !== 32'd0 || lock_lost !== 1'b0) begin errors++;
      $display("FAIL window_cnt: bit=%0d err=%0d lost=%0b, want 800 0 0", bit_cnt, err_cnt, lock_lost); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL window_busy: busy=%0b, want 0", busy); end
  endtask

  task automatic test_errors();
    int da, nd;
    run_meas(100, 10, 3, 0, 0, 0, 0, 0, da, nd);
    checks++; if (err_cnt !== 32'd30 || bit_cnt !== 48'd800 || nd !== 1) begin errors++;
      $display("FAIL errors_cnt: err=%0d bit=%0d pulses=%0d, want 30 800 1", err_cnt, bit_cnt, nd); end
  endtask

  task automatic test_lock_drop();
    int da, nd;
    run_meas(100, 0, 0, 41, 20, 0, 0, 0, da, nd);
    checks++; if (bit_cnt !== 48'd800 || lock_lost !== 1'b1 || da !== 121 || nd !== 1) begin errors++;
      $display("FAIL lock_drop: bit=%0d lost=%0b at=%0d pulses=%0d, want 800 1 121 1", bit_cnt, lock_lost, da, nd); end
    run_meas(100, 0, 0, 0, 0, 41, 50, 0, da, nd);
    checks++; if (bit_cnt !== 48'd800 || lock_lost !== 1'b0 || da !== 151 || nd !== 1) begin errors++;
      $display("FAIL en_drop: bit=%0d lost=%0b at=%0d pulses=%0d, want 800 0 151 1", bit_cnt, lock_lost, da, nd); end
  endtask

  task automatic test_stop();
    int da, nd;
    run_meas(0, 0, 0, 0, 0, 0, 0, 52, da, nd);
    checks++; if (bit_cnt !== 48'd408 || da !== 52 || nd !== 1) begin errors++;
      $display("FAIL stop_measure: bit=%0d at=%0d pulses=%0d, want 408 52 1", bit_cnt, da, nd); end
    run_meas(0, 0, 0, 1, 400, 0, 0, 1, da, nd);
    checks++; if (bit_cnt !== 48'd0 || da !== 1 || nd !== 1 || lock_lost !== 1'b0) begin errors++;
      $display("FAIL stop_wait: bit=%0d at=%0d pulses=%0d lost=%0b, want 0 1 1 0", bit_cnt, da, nd, lock_lost); end
  endtask

  task automatic test_saturation();
    int da, nd;
    run_meas(4, 1, 8, 0, 0, 0, 0, 0, da, nd);
    checks++; if (s_err_cnt !== 4'd15 || s_err_sat !== 1'b1 || s_bit_cnt !== 48'd32) begin errors++;
      $display("FAIL sat_small: err=%0d sat=%0b bit=%0d, want 15 1 32", s_err_cnt, s_err_sat, s_bit_cnt); end
    checks++; if (err_cnt !== 32'd32 || err_sat !== 1'b0) begin errors++;
      $display("FAIL sat_wide: err=%0d sat=%0b, want 32 0", err_cnt, err_sat); end
    // Reset during a fresh measurement: aborts silently.
    lock = 1; en = 1; err_num = 2; start = 1; window = 20;
    tick();
    start = 0;
    repeat (10) tick();
    reset = 0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bit_cnt !== 48'd0 || err_cnt !== 32'd0 ||
                  s_err_cnt !== 4'd0 || lock_lost !== 1'b0 || err_sat !== 1'b0) begin errors++;
      $display("FAIL reset_mid: busy=%0b done=%0b bit=%0d err=%0d, want all 0", busy, done, bit_cnt, err_cnt); end
    reset = 1;
    nd = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (done || s_done) nd++; end
    checks++; if (nd !== 0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_nodone: pulses=%0d busy=%0b, want 0 0", nd, busy); end
    err_num = 0;
  endtask

  task automatic test_back_to_back();
    int da;
    da = -1;
    lock = 1; en = 1; stop = 0; start = 1; window = 10;
    tick();
    window = 50;
    for (int i = 1; i <= 11; i++) begin tick(); if (done && da < 0) da = i; end
    checks++; if (da !== 11 || bit_cnt !== 48'd80) begin errors++;
      $display("FAIL start_ignored: at=%0d bit=%0d, want 11 80", da, bit_cnt); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL start_in_done: busy=%0b done=%0b, want 0 0", busy, done); end
    stop = 1;
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL start_stop_idle: busy=%0b done=%0b, want 1 0", busy, done); end
    start = 0;
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || bit_cnt !== 48'd0) begin errors++;
      $display("FAIL stop_after_start: done=%0b busy=%0b bit=%0d, want 1 0 0", done, busy, bit_cnt); end
    stop = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 9) < 7);
      lock    = ($urandom_range(0, 9) != 0);
      err_num = 9'($urandom_range(0, 8));
      window  = $urandom_range(0, 25);
      tick();
      checks++; if (busy !== (m_phase == 1 || m_phase == 2) || done !== (m_phase == 3)) begin errors++;
        if (errors < 20) $display("FAIL rand_ctrl @%0d: busy=%0b done=%0b, want phase %0d", i, busy, done, m_phase); end
      checks++; if (bit_cnt !== m_bits[47:0] || s_bit_cnt !== m_bits[47:0]) begin errors++;
        if (errors < 20) $display("FAIL rand_bits @%0d: got %0d, want %0d", i, bit_cnt, m_bits); end
      checks++; if (err_cnt !== m_err[31:0] || err_sat !== m_sat) begin errors++;
        if (errors < 20) $display("FAIL rand_err @%0d: got %0d/%0b, want %0d/%0b", i, err_cnt, err_sat, m_err, m_sat); end
      checks++; if (s_err_cnt !== m_serr[3:0] || s_err_sat !== m_ssat) begin errors++;
        if (errors < 20) $display("FAIL rand_serr @%0d: got %0d/%0b, want %0d/%0b", i, s_err_cnt, s_err_sat, m_serr, m_ssat); end
      checks++; if (lock_lost !== m_lost) begin errors++;
        if (errors < 20) $display("FAIL rand_lost @%0d: got %0b, want %0b", i, lock_lost, m_lost); end
    end
    reset = 1; start = 0; stop = 0;
  endtask

  initial begin
    test_reset();
    test_window();
    test_errors();
    test_lock_drop();
    test_stop();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
